// File: rtl/mux_n_rr_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_n_rr_reg_if
// Description : Bundle of the select, per-channel input handshake and single
//               output handshake signals of the N:1 registered multiplexer.
//               Optional macro MUX_LAST_LOCK_EN adds in_last / out_last.
// Modports    : slave  - multiplexer side (consumes inputs, drives outputs)
//               master - producer/consumer side (bench or surrounding logic)
// Signals     : mode, sel, in_valid, in_ready, in_data,
//               out_valid, out_ready, out_data, out_ch [, in_last, out_last]
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_n_rr_reg_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int SELW = $clog2(N);

  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [N*WIDTH-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
`ifdef MUX_LAST_LOCK_EN
  logic [N-1:0]         in_last;
  logic                 out_last;
`endif

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
`ifdef MUX_LAST_LOCK_EN
    input  in_last,
    output out_last,
`endif
    output in_ready, out_valid, out_data, out_ch
  );

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
`ifdef MUX_LAST_LOCK_EN
    output in_last,
    input  out_last,
`endif
    input  in_ready, out_valid, out_data, out_ch
  );

endinterface
`default_nettype wire

// File: rtl/mux_n_rr_reg.sv
`default_nettype none
// ============================================================================
// Module      : mux_n_rr_reg
// Description : Parametrised N:1 registered multiplexer with valid/ready
//               handshake per channel. Grant comes from sel (mode=0) or a
//               round-robin search starting at rr_ptr (mode=1). Output is a
//               single register stage, 1 beat/cycle under full throughput.
// Macro       : MUX_LAST_LOCK_EN - adds in_last/out_last; a beat without
//               in_last locks the grant onto its channel until the last beat.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - mux_n_rr_reg_if.slave (select, inputs, output)
// Revision    : 1.0 - initial release
// ============================================================================
module mux_n_rr_reg #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_n_rr_reg_if.slave     bus
);

  localparam int              SELW    = $clog2(N);
  localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);

  // Output register stage and arbitration state
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_ch_q,    out_ch_d;
  logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;
`ifdef MUX_LAST_LOCK_EN
  logic             lock_q,      lock_d;
  logic [SELW-1:0]  lock_ch_q,   lock_ch_d;
  logic             out_last_q,  out_last_d;
`endif

  // Combinational grant path
  logic             load_en;
  logic             grant_vld;
  logic [SELW-1:0]  grant_ch;
  logic [SELW-1:0]  cand;
  logic             ready_ok;
  logic [N-1:0]     ready_vec;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  // Output slot is free, or its current beat leaves this cycle.
  assign load_en = !out_valid_q || bus.out_ready;

  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    cand      = '0;
`ifdef MUX_LAST_LOCK_EN
    if (lock_q) begin
      // A multi-beat packet is in flight: stay on its channel.
      grant_vld = 1'b1;
      grant_ch  = lock_ch_q;
    end else
`endif
    if (!bus.mode) begin
      if (int'(bus.sel) < N) begin
        grant_vld = 1'b1;
        grant_ch  = bus.sel;
      end
    end else begin
      // Walk from the farthest candidate back towards rr_ptr so the last
      // hit written is the first valid channel at or after rr_ptr.
      for (int k = N - 1; k >= 0; k--) begin
        cand = SELW'((int'(rr_ptr_q) + k) % N);
        if (bus.in_valid[cand]) begin
          grant_vld = 1'b1;
          grant_ch  = cand;
        end
      end
    end
  end

  // In manual/locked-manual mode ready is offered regardless of valid; in
  // round-robin mode only a valid channel can be granted anyway. Ready is
  // forced low while reset is asserted.
  assign ready_ok   = rst_n && load_en && grant_vld &&
                      (!bus.mode || bus.in_valid[grant_ch]);
  assign xfer       = ready_ok && bus.in_valid[grant_ch];
  assign grant_data = bus.in_data[int'(grant_ch) * WIDTH +: WIDTH];

  always_comb begin
    ready_vec = '0;
    if (ready_ok) begin
      ready_vec[grant_ch] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef MUX_LAST_LOCK_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    out_last_d  = out_last_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_ch_d    = grant_ch;
      rr_ptr_d    = (grant_ch == LAST_CH) ? '0 : grant_ch + SELW'(1);
`ifdef MUX_LAST_LOCK_EN
      lock_d      = !bus.in_last[grant_ch];
      lock_ch_d   = grant_ch;
      out_last_d  = bus.in_last[grant_ch];
`endif
    end else if (load_en) begin
      // Slot drained with nothing to replace it; data/ch keep last value.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
`ifdef MUX_LAST_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef MUX_LAST_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign bus.in_ready  = ready_vec;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
`ifdef MUX_LAST_LOCK_EN
  assign bus.out_last  = out_last_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_n_rr_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_n_rr_reg
// Description : Self-checking bench for mux_n_rr_reg. Main instance N=4,
//               WIDTH=8; a second N=3 instance exercises out-of-range sel and
//               wrap on a non power-of-two channel count.
//               Honours MUX_LAST_LOCK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_n_rr_reg;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int SELW  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_n_rr_reg_if #(.N(N), .WIDTH(WIDTH)) bus  ();
  mux_n_rr_reg_if #(.N(3), .WIDTH(WIDTH)) bus3 ();

  mux_n_rr_reg #(.N(N), .WIDTH(WIDTH)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  mux_n_rr_reg #(.N(3), .WIDTH(WIDTH)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int tests = 0;
  int fails = 0;

  // Reference state for the N=4 instance
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic [SELW-1:0]  m_ch;
  int               m_rr;
  bit               m_lock;
  int               m_lock_ch;
  bit               m_last;
  logic [N-1:0]     exp_rdy;
  logic [N-1:0]     obs_rdy;

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_ch = '0; m_rr = 0;
    m_lock = 1'b0; m_lock_ch = 0; m_last = 1'b0;
  endtask

  // Channel chosen this cycle, or -1 when nobody is granted.
  function automatic int model_grant();
    if (m_lock) return m_lock_ch;
    if (!bus.mode) return (int'(bus.sel) < N) ? int'(bus.sel) : -1;
    for (int k = 0; k < N; k++)
      if (bus.in_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  // One clock: predict ready at mid-cycle, then advance model after the edge.
  task automatic cycle();
    int g; bit le; bit xf; logic [WIDTH-1:0] d; bit lst;
    @(negedge clk);
    g  = model_grant();
    le = !m_valid || bus.out_ready;
    exp_rdy = '0;
    if (g >= 0 && le && rst_n && (!bus.mode || bus.in_valid[g])) exp_rdy[g] = 1'b1;
    xf  = (g >= 0) && exp_rdy[g] && bus.in_valid[g];
    d   = (g >= 0) ? bus.in_data[g*WIDTH +: WIDTH] : '0;
    lst = 1'b1;
`ifdef MUX_LAST_LOCK_EN
    if (g >= 0) lst = bus.in_last[g];
`endif
    obs_rdy = bus.in_ready;
    @(posedge clk); #1;
    if (xf) begin
      m_valid = 1'b1; m_data = d; m_ch = SELW'(g); m_rr = (g + 1) % N;
      m_last = lst; m_lock = !lst; m_lock_ch = g;
    end else if (le) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic drive_idle();
    bus.mode = 1'b0; bus.sel = '0; bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus3.mode = 1'b0; bus3.sel = '0; bus3.in_valid = '0; bus3.in_data = '0; bus3.out_ready = 1'b0;
`ifdef MUX_LAST_LOCK_EN
    bus.in_last = '1; bus3.in_last = '1;
`endif
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    bus.mode = 1'b1; bus.in_valid = '1; bus.out_ready = 1'b1;
    bus.in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    repeat (3) cycle();
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    tests++; if (bus.out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
    tests++; if (bus.out_ch !== 2'd0) begin fails++; $display("FAIL reset_out_ch got=%0d exp=0", bus.out_ch); end
    tests++; if (bus.in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready got=%b exp=0000", bus.in_ready); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_manual();
    do_reset();
    bus.mode = 1'b0; bus.sel = 2'd2; bus.in_valid = 4'b0100; bus.out_ready = 1'b1;
    bus.in_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    cycle();
    tests++; if (obs_rdy !== 4'b0100) begin fails++; $display("FAIL manual_in_ready got=%b exp=0100", obs_rdy); end
    tests++; if (bus.out_data !== 8'hA5) begin fails++; $display("FAIL manual_out_data got=%h exp=a5", bus.out_data); end
    tests++; if (bus.out_ch !== 2'd2) begin fails++; $display("FAIL manual_out_ch got=%0d exp=2", bus.out_ch); end
    bus.in_valid = 4'b0000;
    cycle();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL manual_drain got=%b exp=0", bus.out_valid); end
  endtask

  // N=3 instance: sel=3 selects nothing; rr wraps 2 -> 0.
  task automatic test_sel_range();
    logic [1:0] exp_seq [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    do_reset();
    bus3.mode = 1'b0; bus3.sel = 2'd2; bus3.in_valid = 3'b111; bus3.out_ready = 1'b1;
    bus3.in_data = {8'hC3, 8'hB2, 8'hA1};
    @(negedge clk);
    tests++; if (bus3.in_ready !== 3'b100) begin fails++; $display("FAIL n3_sel2_ready got=%b exp=100", bus3.in_ready); end
    @(posedge clk); #1;
    tests++; if (bus3.out_ch !== 2'd2 || bus3.out_data !== 8'hC3) begin fails++; $display("FAIL n3_sel2_out got=%0d/%h exp=2/c3", bus3.out_ch, bus3.out_data); end
    bus3.sel = 2'd3;
    @(negedge clk);
    tests++; if (bus3.in_ready !== 3'b000) begin fails++; $display("FAIL n3_sel3_ready got=%b exp=000", bus3.in_ready); end
    @(posedge clk); #1;
    tests++; if (bus3.out_valid !== 1'b0) begin fails++; $display("FAIL n3_sel3_valid got=%b exp=0", bus3.out_valid); end
    bus3.mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tests++; if (bus3.out_ch !== exp_seq[i]) begin fails++; $display("FAIL n3_rr_wrap[%0d] got=%0d exp=%0d", i, bus3.out_ch, exp_seq[i]); end
    end
    bus3.in_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    bus.mode = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
    bus.in_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    for (int i = 0; i < 5; i++) begin
      cycle();
      tests++; if (bus.out_ch !== exp_seq[i] || bus.out_valid !== 1'b1) begin fails++; $display("FAIL rr_seq[%0d] got=%0d/v%b exp=%0d/v1", i, bus.out_ch, bus.out_valid, exp_seq[i]); end
    end
  endtask

  task automatic test_skip_wrap();
    logic [1:0] exp_seq [4] = '{2'd3, 2'd1, 2'd3, 2'd1};
    do_reset();
    bus.mode = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 4'b0010;
    cycle();  // ch1 moves rr_ptr to 2
    bus.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cycle();
      tests++; if (bus.out_ch !== exp_seq[i]) begin fails++; $display("FAIL skip_wrap[%0d] got=%0d exp=%0d", i, bus.out_ch, exp_seq[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.mode = 1'b0; bus.sel = 2'd1; bus.in_valid = 4'b0010; bus.out_ready = 1'b1;
    bus.in_data = {8'h00, 8'h00, 8'h3C, 8'h00};
    cycle();
    bus.out_ready = 1'b0;
    bus.in_data = {8'h00, 8'h00, 8'h77, 8'h00};
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++; if (obs_rdy !== 4'b0000) begin fails++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, obs_rdy); end
      tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C || bus.out_ch !== 2'd1) begin fails++; $display("FAIL bp_hold[%0d] got=v%b/%h/%0d exp=v1/3c/1", i, bus.out_valid, bus.out_data, bus.out_ch); end
    end
    bus.out_ready = 1'b1;
    cycle();
    tests++; if (obs_rdy !== 4'b0010) begin fails++; $display("FAIL bp_release_ready got=%b exp=0010", obs_rdy); end
    tests++; if (bus.out_data !== 8'h77) begin fails++; $display("FAIL bp_release_data got=%h exp=77", bus.out_data); end
  endtask

`ifdef MUX_LAST_LOCK_EN
  task automatic test_lock();
    logic [1:0] exp_seq [4] = '{2'd0, 2'd0, 2'd0, 2'd1};
    logic [3:0] last_seq [4] = '{4'b1110, 4'b1110, 4'b1111, 4'b1111};
    do_reset();
    bus.mode = 1'b1; bus.in_valid = 4'b0011; bus.out_ready = 1'b1;
    bus.in_data = {8'h00, 8'h00, 8'hB1, 8'hB0};
    for (int i = 0; i < 4; i++) begin
      bus.in_last = last_seq[i];
      cycle();
      tests++; if (bus.out_ch !== exp_seq[i]) begin fails++; $display("FAIL lock_seq[%0d] got=%0d exp=%0d", i, bus.out_ch, exp_seq[i]); end
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.mode      = ($urandom_range(0, 7) < 5);
      bus.sel       = SELW'($urandom);
      bus.in_valid  = N'($urandom);
      bus.in_data   = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_LAST_LOCK_EN
      bus.in_last   = N'($urandom);
`endif
      cycle();
      tests++; if (obs_rdy !== exp_rdy) begin fails++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", c, obs_rdy, exp_rdy); end
      tests++; if (bus.out_valid !== m_valid) begin fails++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", c, bus.out_valid, m_valid); end
      tests++; if (bus.out_data !== m_data) begin fails++; $display("FAIL rand_out_data cyc=%0d got=%h exp=%h", c, bus.out_data, m_data); end
      tests++; if (bus.out_ch !== m_ch) begin fails++; $display("FAIL rand_out_ch cyc=%0d got=%0d exp=%0d", c, bus.out_ch, m_ch); end
`ifdef MUX_LAST_LOCK_EN
      tests++; if (bus.out_last !== m_last) begin fails++; $display("FAIL rand_out_last cyc=%0d got=%b exp=%b", c, bus.out_last, m_last); end
`endif
    end
  endtask

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_manual();
    test_sel_range();
    test_round_robin();
    test_skip_wrap();
    test_backpressure();
`ifdef MUX_LAST_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
